// File: rtl/fc3_pkg.sv
// Shared constants, FSM state type and weight-address helper for the layer-3 classifier.
package fc3_pkg;

  localparam int unsigned N_IN  = 15;
  localparam int unsigned N_OUT = 10;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned ACCW  = 36;
  // Index widths for the activation (i) and output-class (o) counters.
  localparam int unsigned IW    = 4;
  localparam int unsigned OW    = 4;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } state_e;

  // Weights are stored output-major: all N_IN weights of class o are contiguous.
  function automatic logic [AW-1:0] w_addr(input logic [OW-1:0] o, input logic [IW-1:0] i);
    return AW'(o) * AW'(N_IN) + AW'(i);
  endfunction

endpackage

// File: rtl/fc3_mac_unit.sv
// Product register followed by a reloadable accumulator; flags the final term of each dot product.
module fc3_mac_unit
  import fc3_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_first,
  input  logic            in_last,
  input  logic [DW-1:0]   act,
  input  logic [DW-1:0]   weight,
  output logic [ACCW-1:0] acc,
  output logic            acc_done
);

  logic [2*DW-1:0] prod_q;
  logic            p_valid_q, p_first_q, p_last_q;
  logic [ACCW-1:0] acc_q;
  logic            done_q;
  logic [ACCW-1:0] prod_ext;

  assign prod_ext = {{(ACCW - 2 * DW){prod_q[2*DW-1]}}, prod_q};

  // Stage 1: register the signed product and its control flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q    <= '0;
      p_valid_q <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
    end else begin
      prod_q    <= $signed({{DW{act[DW-1]}}, act}) * $signed({{DW{weight[DW-1]}}, weight});
      p_valid_q <= in_valid;
      p_first_q <= in_first;
      p_last_q  <= in_last;
    end
  end

  // Stage 2: reload on the first term of a class, otherwise accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (p_valid_q) begin
        acc_q <= p_first_q ? prod_ext : acc_q + prod_ext;
      end
      done_q <= p_valid_q & p_last_q;
    end
  end

  assign acc      = acc_q;
  assign acc_done = done_q;

endmodule

// File: rtl/fc3_mac_argmax.sv
// Layer-3 fully-connected layer with arg-max: buffers a frame, streams weights, reports best class.
module fc3_mac_argmax
  import fc3_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_digit,
  output logic [ACCW-1:0] out_score,
  output logic            rom_ce,
  output logic            rom_oce,
  output logic            rom_reset,
  output logic [AW-1:0]   rom_ad,
  input  logic [DW-1:0]   rom_dout
);

  state_e          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic [IW-1:0]   i_q, i_d;
  logic [OW-1:0]   o_q, o_d;
  logic [OW-1:0]   cmp_o_q, cmp_o_d;
  logic            rom_ce_q, rom_ce_d;
  logic [AW-1:0]   rom_ad_q, rom_ad_d;
  logic            rd_valid_q;
  logic [IW-1:0]   rd_i_q;
  logic [ACCW-1:0] best_q, best_d;
  logic [OW-1:0]   best_idx_q, best_idx_d;
  logic [DW-1:0]   act_q [N_IN];
  logic [ACCW-1:0] acc;
  logic            acc_done;
  logic            accept, last_issue, better;

  assign in_ready   = (state_q == StIdle) || (state_q == StLoad);
  assign accept     = in_valid && in_ready;
  assign last_issue = (o_q == OW'(N_OUT - 1)) && (i_q == IW'(N_IN - 1));
  // Class 0 always seeds the tracker; strict compare keeps the lowest index on ties.
  assign better     = (cmp_o_q == '0) || ($signed(acc) > $signed(best_q));

  assign out_valid = (state_q == StDone);
  assign out_digit = best_idx_q;
  assign out_score = best_q;
  assign rom_ce    = rom_ce_q;
  assign rom_ad    = rom_ad_q;
  assign rom_oce   = 1'b1;
  assign rom_reset = 1'b0;

  // Next-state logic: beat collection, address issue and arg-max tracking.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    i_d        = i_q;
    o_d        = o_q;
    cmp_o_d    = cmp_o_q;
    rom_ce_d   = rom_ce_q;
    rom_ad_d   = rom_ad_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (accept) begin
          k_d     = k_q + 1'b1;
          state_d = StLoad;
          if (k_q == IW'(N_IN - 1)) begin
            k_d      = '0;
            state_d  = StRun;
            i_d      = '0;
            o_d      = '0;
            cmp_o_d  = '0;
            rom_ce_d = 1'b1;
            rom_ad_d = w_addr('0, '0);
          end
        end
      end
      StRun: begin
        if (rom_ce_q) begin
          if (last_issue) begin
            rom_ce_d = 1'b0;
          end else begin
            if (i_q == IW'(N_IN - 1)) begin
              i_d = '0;
              o_d = o_q + 1'b1;
            end else begin
              i_d = i_q + 1'b1;
            end
            rom_ad_d = w_addr(o_d, i_d);
          end
        end
        if (acc_done) begin
          if (better) begin
            best_d     = acc;
            best_idx_d = cmp_o_q;
          end
          cmp_o_d = cmp_o_q + 1'b1;
          if (cmp_o_q == OW'(N_OUT - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      i_q        <= '0;
      o_q        <= '0;
      cmp_o_q    <= '0;
      rom_ce_q   <= 1'b0;
      rom_ad_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_i_q     <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      i_q        <= i_d;
      o_q        <= o_d;
      cmp_o_q    <= cmp_o_d;
      rom_ce_q   <= rom_ce_d;
      rom_ad_q   <= rom_ad_d;
      // ROM data arrives one cycle after the issue edge; track its activation index.
      rd_valid_q <= rom_ce_q;
      rd_i_q     <= i_q;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

  // Activation buffer; only written on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned n = 0; n < N_IN; n++) begin
        act_q[n] <= '0;
      end
    end else if (accept) begin
      act_q[k_q] <= in_data;
    end
  end

  fc3_mac_unit u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_valid_q),
    .in_first (rd_i_q == '0),
    .in_last  (rd_i_q == IW'(N_IN - 1)),
    .act      (act_q[rd_i_q]),
    .weight   (rom_dout),
    .acc      (acc),
    .acc_done (acc_done)
  );

endmodule

// File: tb/tb_fc3_mac_argmax.sv
// Self-checking bench: ROM model, dot-product/arg-max reference model and per-cycle compare.
module tb_fc3_mac_argmax;
  import fc3_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic [DW-1:0]   rom_dout = '0;
  logic            in_ready, out_valid, rom_ce, rom_oce, rom_reset;
  logic [3:0]      out_digit;
  logic [ACCW-1:0] out_score;
  logic [AW-1:0]   rom_ad;

  always #5 clk = ~clk;

  fc3_mac_argmax dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_digit (out_digit),
    .out_score (out_score),
    .rom_ce    (rom_ce),
    .rom_oce   (rom_oce),
    .rom_reset (rom_reset),
    .rom_ad    (rom_ad),
    .rom_dout  (rom_dout)
  );

  logic [DW-1:0] rom_img [256];
  logic [DW-1:0] act_m [N_IN];
  int            n_checks = 0;
  int            n_fail = 0;
  int            exp_digit = 0;
  longint        exp_score = 0;
  bit            chk_en = 1'b0;

  // Weight ROM: one-cycle synchronous read.
  always @(posedge clk) if (rom_ce) rom_dout <= rom_img[rom_ad];

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (chk_en && rst_n && out_valid) begin
      check("out_digit", longint'(out_digit), longint'(exp_digit));
      check("out_score", longint'($signed(out_score)), exp_score);
    end
  end

  // Reference: plain dot products over the ROM image, first maximum wins.
  task automatic model(output int d, output longint s);
    longint sc;
    d = 0;
    s = 0;
    for (int o = 0; o < int'(N_OUT); o++) begin
      sc = 0;
      for (int i = 0; i < int'(N_IN); i++) begin
        sc += longint'($signed(act_m[i])) * longint'($signed(rom_img[o * int'(N_IN) + i]));
      end
      if (o == 0 || sc > s) begin
        s = sc;
        d = o;
      end
    end
  endtask

  task automatic set_img(input int mode);
    for (int a = 0; a < 256; a++) begin
      case (mode)
        0:       rom_img[a] = DW'(a);
        1:       rom_img[a] = DW'(-a);
        2:       rom_img[a] = 16'h8000;
        default: rom_img[a] = DW'($urandom);
      endcase
    end
  endtask

  task automatic set_act(input int mode);
    for (int k = 0; k < int'(N_IN); k++) begin
      case (mode)
        0:       act_m[k] = '0;
        1:       act_m[k] = 16'd1;
        2:       act_m[k] = 16'h8000;
        default: act_m[k] = DW'($urandom);
      endcase
    end
  endtask

  task automatic send_beats(input int gap_max, input bit junk);
    for (int k = 0; k < int'(N_IN); k++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          in_valid = 1'b0;
          in_data  = DW'($urandom);
          @(posedge clk);
          #1;
        end
      end
      in_valid = 1'b1;
      in_data  = act_m[k];
      @(posedge clk);
      #1;
    end
    in_valid = junk;
    in_data  = DW'($urandom);
  endtask

  task automatic run_frame(input string tag, input int gap_max, input int stall, input bit junk,
                           input bit use_lit, input int lit_d, input longint lit_s);
    int cnt, ce_cnt, ad_bad;
    model(exp_digit, exp_score);
    if (use_lit) begin
      check({tag, "_model_digit"}, longint'(exp_digit), longint'(lit_d));
      check({tag, "_model_score"}, exp_score, lit_s);
    end
    send_beats(gap_max, junk);
    cnt = 0;
    ce_cnt = 0;
    ad_bad = 0;
    while (!out_valid && cnt < 400) begin
      if (rom_ce) begin
        if (rom_ad != AW'(ce_cnt)) ad_bad++;
        ce_cnt++;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (junk) in_data = DW'($urandom);
    end
    check({tag, "_latency"}, longint'(cnt), 153);
    if (cnt >= 400) begin
      in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      return;
    end
    check({tag, "_rom_ce_cycles"}, longint'(ce_cnt), 150);
    check({tag, "_rom_ad_seq_errors"}, longint'(ad_bad), 0);
    if (use_lit) begin
      check({tag, "_lit_digit"}, longint'(out_digit), longint'(lit_d));
      check({tag, "_lit_score"}, longint'($signed(out_score)), lit_s);
    end
    repeat (stall) begin
      check({tag, "_stall_in_ready"}, longint'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    check({tag, "_held_valid"}, longint'(out_valid), 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_post_hs_valid"}, longint'(out_valid), 0);
    check({tag, "_post_hs_in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    set_img(0);
    #1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_digit", longint'(out_digit), 0);
    check("rst_out_score", longint'(out_score), 0);
    check("rst_rom_ce", longint'(rom_ce), 0);
    check("rst_rom_ad", longint'(rom_ad), 0);
    check("rom_oce", longint'(rom_oce), 1);
    check("rom_reset", longint'(rom_reset), 0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;

    set_img(0); set_act(0);
    run_frame("zeros", 0, 0, 0, 1'b1, 0, 0);
    set_img(0); set_act(1);
    run_frame("ones", 0, 0, 0, 1'b1, 9, 2130);
    set_img(1); set_act(1);
    run_frame("neg", 0, 2, 1, 1'b1, 0, -105);
    set_img(2); set_act(2);
    run_frame("minval", 0, 0, 0, 1'b1, 0, 64'sd16106127360);

    for (int f = 0; f < 6; f++) begin
      set_img(3); set_act(3);
      run_frame("rand", 3, (f == 0) ? 20 : int'($urandom_range(20, 0)), 1, 1'b0, 0, 0);
    end

    // Abort a frame partway through RUN.
    set_img(0); set_act(1);
    send_beats(0, 0);
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_rom_ce", longint'(rom_ce), 0);
    check("abort_in_ready", longint'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("after_abort", 0, 0, 0, 1'b1, 9, 2130);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
